// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART register bridge. It holds the
// command opcodes, the single-byte reply codes and the bridge FSM state type.
// -----------------------------------------------------------------------------
package uart_pkg;

   // Command opcodes: the first byte of a frame
   localparam logic [7:0] OP_WRITE = 8'h57;  // 'W' addr data
   localparam logic [7:0] OP_READ  = 8'h52;  // 'R' addr

   // Reply bytes pushed into the TX FIFO
   localparam logic [7:0] RSP_ACK  = 8'h4B;  // 'K' write done
   localparam logic [7:0] RSP_NAK  = 8'h15;  // unknown opcode

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_ADDR,
      S_GET_DATA,
      S_DO_WRITE,
      S_DO_READ,
      S_READ_WAIT,
      S_SEND
   } bridge_state_t;

endpackage

// File: rtl/uart_reg_bridge.sv
// -----------------------------------------------------------------------------
// uart_reg_bridge
// Sits between the UART RX FIFO (first-word-fall-through) and the UART TX
// FIFO. The bridge parses 'W' addr data and 'R' addr frames, drives a simple
// 8-bit register bus and returns a single reply byte per frame. An
// inter-byte timeout abandons frames that stall mid-way. A saturating error
// counter tallies unknown opcodes and timeouts.
//
// Ports
//   CLK        system clock
//   rst        synchronous reset, active-high
//   rx_data    RX FIFO head byte, valid while rx_empty=0
//   rx_empty   RX FIFO empty
//   rx_rden    one-cycle pop of the RX FIFO head
//   tx_data    reply byte, held stable while waiting on tx_full
//   tx_wren    one-cycle push into the TX FIFO
//   tx_full    TX FIFO full
//   reg_addr   register address (held until the next frame)
//   reg_wdata  register write data (held until the next frame)
//   reg_we     one-cycle write strobe
//   reg_re     one-cycle read strobe
//   reg_rdata  read data, valid the cycle after reg_re
//   err_count  saturating count of bad opcodes and timeouts
// -----------------------------------------------------------------------------
module uart_reg_bridge
   import uart_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 120000,
   parameter int CNT_W          = 17
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_empty,
   output logic       rx_rden,
   output logic [7:0] tx_data,
   output logic       tx_wren,
   input  logic       tx_full,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic [7:0] err_count
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   bridge_state_t    state;
   logic             is_read;
   logic [CNT_W-1:0] tmo_cnt;
   logic             byte_avail;
   logic             tmo_hit;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // rx_rden is registered, so while it is high the FIFO has not yet popped
   // the byte just taken; that cycle is the mandatory settle gap.
   assign byte_avail = !rx_empty && !rx_rden;
   assign tmo_hit    = (tmo_cnt == TMO_LAST);

   always_ff @(posedge CLK) begin
      if (rst) begin
         state     <= S_IDLE;
         is_read   <= 1'b0;
         tmo_cnt   <= '0;
         rx_rden   <= 1'b0;
         tx_data   <= 8'h00;
         tx_wren   <= 1'b0;
         reg_addr  <= 8'h00;
         reg_wdata <= 8'h00;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         err_count <= 8'h00;
      end else begin
         rx_rden <= 1'b0;
         tx_wren <= 1'b0;
         reg_we  <= 1'b0;
         reg_re  <= 1'b0;

         case (state)
            S_IDLE: begin
               if (byte_avail) begin
                  rx_rden <= 1'b1;
                  tmo_cnt <= '0;
                  if (rx_data == OP_WRITE) begin
                     is_read <= 1'b0;
                     state   <= S_GET_ADDR;
                  end else if (rx_data == OP_READ) begin
                     is_read <= 1'b1;
                     state   <= S_GET_ADDR;
                  end else begin
                     tx_data   <= RSP_NAK;
                     err_count <= sat_inc(err_count);
                     state     <= S_SEND;
                  end
               end
            end

            S_GET_ADDR: begin
               // A byte arriving on the expiry cycle still wins.
               if (byte_avail) begin
                  rx_rden  <= 1'b1;
                  reg_addr <= rx_data;
                  tmo_cnt  <= '0;
                  if (is_read) begin
                     // Strobe rises together with entry so the bus sees
                     // reg_re during DO_READ and rdata lands in READ_WAIT.
                     reg_re <= 1'b1;
                     state  <= S_DO_READ;
                  end else begin
                     state  <= S_GET_DATA;
                  end
               end else if (tmo_hit) begin
                  tmo_cnt   <= '0;
                  err_count <= sat_inc(err_count);
                  state     <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end

            S_GET_DATA: begin
               if (byte_avail) begin
                  rx_rden   <= 1'b1;
                  reg_wdata <= rx_data;
                  tmo_cnt   <= '0;
                  state     <= S_DO_WRITE;
               end else if (tmo_hit) begin
                  tmo_cnt   <= '0;
                  err_count <= sat_inc(err_count);
                  state     <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end

            S_DO_WRITE: begin
               reg_we  <= 1'b1;
               tx_data <= RSP_ACK;
               state   <= S_SEND;
            end

            S_DO_READ: begin
               state <= S_READ_WAIT;
            end

            S_READ_WAIT: begin
               tx_data <= reg_rdata;
               state   <= S_SEND;
            end

            S_SEND: begin
               // No timeout here: a full TX FIFO may stall indefinitely.
               if (!tx_full) begin
                  tx_wren <= 1'b1;
                  state   <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
Command bridge downstream of the UART receive FIFO and upstream of the UART transmit FIFO. It pops received bytes, parses a 2- or 3-byte command frame, and performs single-byte register reads and writes on an 8-bit register bus. It pushes a one-byte reply into the TX FIFO, which lets a host PC poke design registers over the serial link. It also provides an inter-byte timeout and a saturating error counter.

Parameters:
TIMEOUT_CYCLES, 120000, idle CLK cycles allowed between bytes of one frame (10 ms at 12 MHz); must be ≥2.
CNT_W, 17, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
CLK  in  1  system clock
rst  in  1  synchronous reset, active-high
rx_data  in  8  RX FIFO head byte; valid whenever rx_empty=0 (first-word-fall-through)
rx_empty  in  1  RX FIFO empty
rx_rden  out  1  one-cycle pop of RX FIFO head
tx_data  out  8  reply byte to TX FIFO
tx_wren  out  1  one-cycle push into TX FIFO
tx_full  in  1  TX FIFO full
reg_addr  out  8  register address
reg_wdata  out  8  register write data
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe
reg_rdata  in  8  read data; valid exactly 1 cycle after reg_re
err_count  out  8  saturating count of bad opcodes and timeouts

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, err_count 0. Reset mid-frame discards the partial frame. No reg_we or tx_wren is issued after reset.
- Frame formats:
  - Write: 0x57 ('W'), addr, data. Reply 0x4B ('K') after the write.
  - Read: 0x52 ('R'), addr. Reply is the register value.
  - Any other first byte: reply 0x15 (NAK), err_count+1.
- Byte fetch: in a fetch state with rx_empty=0, sample rx_data and assert rx_rden for exactly one cycle. The next cycle is a mandatory gap with no rx_rden, so the FIFO status can settle. This limits intake to 1 byte per 2 cycles. rx_rden is never asserted while rx_empty=1.
- States:
  - IDLE: fetch opcode. W→GET_ADDR; R→GET_ADDR (read flag set); other→SEND with NAK.
  - GET_ADDR: fetch into reg_addr. Write→GET_DATA; read→DO_READ.
  - GET_DATA: fetch into reg_wdata →DO_WRITE.
  - DO_WRITE: reg_we=1 for one cycle, reply byte ← 0x4B →SEND.
  - DO_READ: reg_re=1 for one cycle →READ_WAIT.
  - READ_WAIT: reply byte ← reg_rdata →SEND.
  - SEND: hold tx_data. When tx_full=0, assert tx_wren for one cycle →IDLE. While tx_full=1, wait indefinitely; no timeout applies.
- reg_addr and reg_wdata hold their values until the next frame overwrites them.
- Timeout:
  - The counter runs only in GET_ADDR and GET_DATA.
  - It clears to 0 on entry to those states and on every byte popped.
  - When it reaches TIMEOUT_CYCLES-1 with no byte available, the frame is abandoned: →IDLE, no reply, no register strobe, err_count+1.
  - If a byte is available in the same cycle the counter expires, the byte wins and no timeout occurs.
- err_count saturates at 0xFF. A NAK and a timeout cannot coincide.
- End-to-end latency: a write command produces reg_we 1 cycle after the data byte's pop. A read produces tx_wren 3 cycles after the addr pop when tx_full=0.
- Strobe exclusivity: reg_we and reg_re are mutually exclusive, and at most one tx_wren is issued per frame.

Decomposition:
- uart_pkg holds:
  - opcode constants OP_WRITE=0x57 and OP_READ=0x52
  - reply constants RSP_ACK=0x4B and RSP_NAK=0x15
  - the bridge state enum
- No sub-module: a single FSM plus the timeout counter and error counter, about 200 lines.

Test Plan:
- FIFO presents 0x57,0x10,0xA5 → one reg_we with reg_addr=0x10 and reg_wdata=0xA5, then tx_wren with tx_data=0x4B; err_count=0.
- 0x52,0x22 with reg_rdata=0x3C on the cycle after reg_re → single reg_re, then tx_wren with tx_data=0x3C.
- Opcode 0x41 → tx_data=0x15, err_count=1, no reg strobes; next valid write frame still succeeds.
- 0x57,0x10 then silence for TIMEOUT_CYCLES (use 16) → no reg_we, no tx_wren, err_count+1, back in IDLE. A following 0x52,0x05 frame is parsed correctly.
- Read reply with tx_full=1 for 50 cycles → tx_data stable, tx_wren=0 throughout, single tx_wren after tx_full drops. rx_rden is never asserted while rx_empty=1.
- rst pulsed after 0x57,0x10 → all outputs 0, no reg_we; 300 NAK frames → err_count saturates at 0xFF.
